// File: rtl/avr_fetch_q.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : avr_fetch_q                                                   |
// | Purpose  : Prefetching instruction-fetch unit for the AVR core. Streams  |
// |            16-bit program words into a DEPTH-word queue, assembles one-  |
// |            and two-word instructions and hands them to the CPU over a    |
// |            valid/ready handshake. Handles SEQ, REL, ABS and SKIP flow    |
// |            control and squashes in-flight responses on redirect.         |
// | Ports    : CLK/RST             clock, async active-low reset             |
// |            pc_src/jmp/rel_off  flow-control command and targets          |
// |            prog_req/prog_addr  program memory read request               |
// |            prog_valid/prog_data in-order read response                   |
// |            cur_instr/instr_k/instr_is32/instr_pc  head instruction       |
// |            instr_valid/instr_ready  delivery handshake                   |
// |            queue_level         words currently held in the queue         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module avr_fetch_q #(
   parameter int PC_W  = 16,
   parameter int DEPTH = 4,
   parameter int REL_W = 12
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [2:0]               pc_src,
   input  logic [PC_W-1:0]          jmp,
   input  logic [REL_W-1:0]         rel_off,
   output logic                     prog_req,
   output logic [PC_W-1:0]          prog_addr,
   input  logic                     prog_valid,
   input  logic [15:0]              prog_data,
   output logic [15:0]              cur_instr,
   output logic [15:0]              instr_k,
   output logic                     instr_is32,
   output logic [PC_W-1:0]          instr_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   queue_level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   localparam logic [2:0] SRC_REL  = 3'd1;
   localparam logic [2:0] SRC_ABS  = 3'd2;
   localparam logic [2:0] SRC_SKIP = 3'd3;

   logic [15:0]     data_q [0:DEPTH-1];
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0] resp_pc_q,  resp_pc_d;   // address of the next word to be pushed
   logic [PC_W-1:0] next_pc_q,  next_pc_d;
   logic [LW-1:0]   count_q,    count_d;
   logic [LW-1:0]   inflight_q, inflight_d;
   logic [LW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
   logic            skip_pend_q, skip_pend_d;

   logic [15:0]     head_w0, head_w1;
   logic            present, two_word, complete;
   logic [LW-1:0]   size, pop_n;
   logic            accept, skip_pop, push, redirect;
   logic [PC_W-1:0] next_pc_n;

   // Head decode and handshake
   always_comb begin
      head_w0  = data_q[rd_ptr_q];
      head_w1  = data_q[rd_ptr_q + PW'(1)];
      present  = (count_q != '0);
      // JMP/CALL: 1001_010x_xxxx_11xx, LDS/STS: 1001_00xx_xxxx_0000
      two_word = ((head_w0[15:9] == 7'b1001010) && (head_w0[3:2] == 2'b11)) ||
                 ((head_w0[15:10] == 6'b100100) && (head_w0[3:0] == 4'b0000));
      size     = two_word ? LW'(2) : LW'(1);
      complete = present && (!two_word || (count_q >= LW'(2)));

      instr_valid = complete && !skip_pend_q;
      cur_instr   = present ? head_w0 : 16'h0000;
      instr_is32  = present && two_word;
      instr_k     = (instr_is32 && (count_q >= LW'(2))) ? head_w1 : 16'h0000;
      // Queued words are contiguous and end just below resp_pc.
      instr_pc    = present ? (resp_pc_q - PC_W'(count_q)) : '0;
      queue_level = count_q;

      // Credit check counts words still in flight, including ones to be dropped.
      prog_req  = RST && ((LW+1)'(count_q) + (LW+1)'(inflight_q) < (LW+1)'(DEPTH));
      prog_addr = fetch_pc_q;

      accept    = instr_valid && instr_ready;
      skip_pop  = skip_pend_q && complete;
      pop_n     = (accept || skip_pop) ? size : '0;
      push      = prog_valid && (drop_cnt_q == '0);
      redirect  = (pc_src == SRC_REL) || (pc_src == SRC_ABS);
      next_pc_n = accept ? (instr_pc + PC_W'(size)) : next_pc_q;
   end

   // Next-state
   always_comb begin
      fetch_pc_d  = fetch_pc_q + PC_W'(prog_req);
      inflight_d  = inflight_q + LW'(prog_req) - LW'(prog_valid);
      drop_cnt_d  = drop_cnt_q;
      if (prog_valid && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - LW'(1);
      end
      count_d     = count_q + LW'(push) - pop_n;
      rd_ptr_d    = rd_ptr_q + PW'(pop_n);
      wr_ptr_d    = wr_ptr_q + PW'(push);
      resp_pc_d   = resp_pc_q + PC_W'(push);
      next_pc_d   = next_pc_n;
      skip_pend_d = skip_pend_q && !skip_pop;
      if (pc_src == SRC_SKIP) begin
         skip_pend_d = 1'b1;
      end

      if (redirect) begin
         // Everything outstanding after this edge belongs to the old stream.
         count_d     = '0;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         drop_cnt_d  = inflight_d;
         skip_pend_d = 1'b0;
         if (pc_src == SRC_ABS) begin
            fetch_pc_d = jmp;
         end else begin
            fetch_pc_d = next_pc_n + PC_W'(signed'(rel_off));
         end
         resp_pc_d = fetch_pc_d;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         fetch_pc_q  <= '0;
         resp_pc_q   <= '0;
         next_pc_q   <= '0;
         count_q     <= '0;
         inflight_q  <= '0;
         drop_cnt_q  <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         skip_pend_q <= 1'b0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         resp_pc_q   <= resp_pc_d;
         next_pc_q   <= next_pc_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         drop_cnt_q  <= drop_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         skip_pend_q <= skip_pend_d;
      end
   end

   // Queue storage needs no reset: contents are only observed while counted.
   always_ff @(posedge CLK) begin
      if (push) begin
         data_q[wr_ptr_q] <= prog_data;
      end
   end

   a_no_overflow : assert property (@(posedge CLK) disable iff (!RST)
      !(push && (count_q == LW'(DEPTH))));
   a_no_orphan_resp : assert property (@(posedge CLK) disable iff (!RST)
      !(prog_valid && (inflight_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_avr_fetch_q.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_avr_fetch_q                                                |
// | Purpose  : Directed self-checking bench for avr_fetch_q. Instance A uses |
// |            PC_W=16, instance B uses PC_W=8 for address-wrap cases. Each  |
// |            instance has an in-order memory model with set latency.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_avr_fetch_q;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   // Instance A
   logic [2:0]  pc_src = '0;
   logic [15:0] jmp = '0;
   logic [11:0] rel_off = '0;
   logic        prog_req, prog_valid = 1'b0;
   logic [15:0] prog_addr, prog_data = '0;
   logic [15:0] cur_instr, instr_k, instr_pc;
   logic        instr_is32, instr_valid, instr_ready = 1'b0;
   logic [2:0]  queue_level;

   // Instance B
   logic [2:0]  pc_src_b = '0;
   logic [7:0]  jmp_b = '0;
   logic [11:0] rel_off_b = '0;
   logic        prog_req_b, prog_valid_b = 1'b0;
   logic [7:0]  prog_addr_b, instr_pc_b;
   logic [15:0] prog_data_b = '0;
   logic [15:0] cur_instr_b, instr_k_b;
   logic        instr_is32_b, instr_valid_b, instr_ready_b = 1'b0;
   logic [2:0]  queue_level_b;

   avr_fetch_q #(.PC_W(16), .DEPTH(4), .REL_W(12)) u_dut (
      .CLK(CLK), .RST(RST), .pc_src(pc_src), .jmp(jmp), .rel_off(rel_off),
      .prog_req(prog_req), .prog_addr(prog_addr), .prog_valid(prog_valid),
      .prog_data(prog_data), .cur_instr(cur_instr), .instr_k(instr_k),
      .instr_is32(instr_is32), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .queue_level(queue_level)
   );

   avr_fetch_q #(.PC_W(8), .DEPTH(4), .REL_W(12)) u_dut_b (
      .CLK(CLK), .RST(RST), .pc_src(pc_src_b), .jmp(jmp_b), .rel_off(rel_off_b),
      .prog_req(prog_req_b), .prog_addr(prog_addr_b), .prog_valid(prog_valid_b),
      .prog_data(prog_data_b), .cur_instr(cur_instr_b), .instr_k(instr_k_b),
      .instr_is32(instr_is32_b), .instr_pc(instr_pc_b), .instr_valid(instr_valid_b),
      .instr_ready(instr_ready_b), .queue_level(queue_level_b)
   );

   logic [15:0] mem [0:255];
   int          cyc = 0;
   int          lat = 1;
   int          req_cnt = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          due_a[$];
   logic [15:0] adr_a[$];
   int          due_b[$];
   logic [7:0]  adr_b[$];
   logic [15:0] ta;
   logic [7:0]  tb8;

   always @(posedge CLK) cyc <= RST ? cyc + 1 : 0;

   // Memory model A: responses in order, 'lat' cycles after the request.
   always @(negedge CLK) begin
      if (!RST) begin
         due_a.delete(); adr_a.delete();
         prog_valid = 1'b0; prog_data = '0; req_cnt = 0;
      end else begin
         prog_valid = 1'b0;
         if (due_a.size() > 0 && due_a[0] <= cyc) begin
            void'(due_a.pop_front());
            ta = adr_a.pop_front();
            prog_valid = 1'b1;
            prog_data  = mem[ta[7:0]];
         end
         if (prog_req) begin
            due_a.push_back(cyc + lat);
            adr_a.push_back(prog_addr);
            req_cnt++;
         end
      end
   end

   // Memory model B: fixed 1-cycle latency.
   always @(negedge CLK) begin
      if (!RST) begin
         due_b.delete(); adr_b.delete();
         prog_valid_b = 1'b0; prog_data_b = '0;
      end else begin
         prog_valid_b = 1'b0;
         if (due_b.size() > 0 && due_b[0] <= cyc) begin
            void'(due_b.pop_front());
            tb8 = adr_b.pop_front();
            prog_valid_b = 1'b1;
            prog_data_b  = mem[tb8];
         end
         if (prog_req_b) begin
            due_b.push_back(cyc + 1);
            adr_b.push_back(prog_addr_b);
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'(i);
   endtask

   // Ends at the negedge of cycle 0 after release.
   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0; pc_src = '0; instr_ready = 1'b0; pc_src_b = '0; instr_ready_b = 1'b0;
      repeat (2) @(negedge CLK);
      @(posedge CLK); #2;
      RST = 1'b1;
      @(negedge CLK);
   endtask

   // Waits (bounded) for a valid head on A, checks it, optionally issues a
   // flow-control command on its accept edge.
   task automatic expect_instr(input string tag, input logic [15:0] pc, input logic [15:0] w0,
                               input logic [15:0] k, input logic is32, input logic [2:0] src);
      int n = 0;
      while (!instr_valid && n < 50) begin @(negedge CLK); n++; end
      check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
      check_eq({tag, "_pc"},    32'(instr_pc),    32'(pc));
      check_eq({tag, "_w0"},    32'(cur_instr),   32'(w0));
      check_eq({tag, "_k"},     32'(instr_k),     32'(k));
      check_eq({tag, "_is32"},  32'(instr_is32),  32'(is32));
      pc_src = src;
      @(negedge CLK);
      pc_src = 3'd0;
   endtask

   task automatic expect_seq(input string pfx, input logic [15:0] pc);
      logic [7:0] ix;
      ix = pc[7:0];
      expect_instr($sformatf("%s@%0h", pfx, pc), pc, mem[ix], 16'h0000, 1'b0, 3'd0);
   endtask

   task automatic expect_b(input string tag, input logic [7:0] pc, input logic [15:0] w0,
                           input logic [15:0] k, input logic is32, input logic [2:0] src);
      int n = 0;
      while (!instr_valid_b && n < 50) begin @(negedge CLK); n++; end
      check_eq({tag, "_valid"}, 32'(instr_valid_b), 32'd1);
      check_eq({tag, "_pc"},    32'(instr_pc_b),    32'(pc));
      check_eq({tag, "_w0"},    32'(cur_instr_b),   32'(w0));
      check_eq({tag, "_k"},     32'(instr_k_b),     32'(k));
      check_eq({tag, "_is32"},  32'(instr_is32_b),  32'(is32));
      pc_src_b = src;
      @(negedge CLK);
      pc_src_b = 3'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      fill_mem();

      // Reset state
      repeat (3) @(negedge CLK);
      check_eq("rst_req",   32'(prog_req),    32'd0);
      check_eq("rst_valid", 32'(instr_valid), 32'd0);
      check_eq("rst_instr", 32'(cur_instr),   32'd0);
      check_eq("rst_k",     32'(instr_k),     32'd0);
      check_eq("rst_is32",  32'(instr_is32),  32'd0);
      check_eq("rst_pc",    32'(instr_pc),    32'd0);
      check_eq("rst_lvl",   32'(queue_level), 32'd0);

      // Free run over NOPs, 1-cycle latency
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
      lat = 1;
      do_reset();
      instr_ready = 1'b1;
      check_eq("t1_c0_req",   32'(prog_req),    32'd1);
      check_eq("t1_c0_addr",  32'(prog_addr),   32'd0);
      check_eq("t1_c0_valid", 32'(instr_valid), 32'd0);
      @(negedge CLK);
      check_eq("t1_c1_valid", 32'(instr_valid), 32'd0);
      check_eq("t1_c1_addr",  32'(prog_addr),   32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         check_eq($sformatf("t1_c%0d_valid", i + 2), 32'(instr_valid), 32'd1);
         check_eq($sformatf("t1_c%0d_pc", i + 2),    32'(instr_pc),    32'(i));
         check_eq($sformatf("t1_c%0d_lvl", i + 2),   32'(queue_level <= 3'd4), 32'd1);
      end

      // Two-word JMP at pc 2
      fill_mem();
      mem[2] = 16'h940C; mem[3] = 16'h0010;
      do_reset();
      instr_ready = 1'b1;
      expect_seq("t2", 16'd0);
      expect_seq("t2", 16'd1);
      expect_instr("t2_jmp", 16'd2, 16'h940C, 16'h0010, 1'b1, 3'd0);
      expect_seq("t2", 16'd4);

      // Back-pressure with 3-cycle latency
      fill_mem();
      lat = 3;
      do_reset();
      repeat (10) @(negedge CLK);
      check_eq("t3_req_stop", 32'(prog_req),    32'd0);
      check_eq("t3_lvl_full", 32'(queue_level), 32'd4);
      check_eq("t3_req_cnt",  32'(req_cnt),     32'd4);
      instr_ready = 1'b1;
      for (int p = 0; p < 10; p++) expect_seq("t3", 16'(p));

      // ABS with three responses in flight
      lat = 3;
      do_reset();
      repeat (3) @(negedge CLK);
      jmp = 16'h0100; pc_src = 3'd2;
      @(negedge CLK);
      pc_src = 3'd0;
      check_eq("t4_req",  32'(prog_req),    32'd1);
      check_eq("t4_addr", 32'(prog_addr),   32'h0100);
      @(negedge CLK);
      check_eq("t4_addr2", 32'(prog_addr),  32'h0101);
      repeat (2) @(negedge CLK);
      check_eq("t4_lvl_dropped", 32'(queue_level), 32'd0);
      instr_ready = 1'b1;
      expect_seq("t4", 16'h0100);
      expect_seq("t4", 16'h0101);
      expect_seq("t4", 16'h0102);

      // REL -3 on accept of pc 10
      lat = 1;
      do_reset();
      instr_ready = 1'b1;
      for (int p = 0; p < 10; p++) expect_seq("t5", 16'(p));
      rel_off = 12'hFFD;
      expect_instr("t5_rel", 16'd10, mem[10], 16'h0000, 1'b0, 3'd1);
      expect_seq("t5r", 16'd8);
      expect_seq("t5r", 16'd9);
      expect_seq("t5r", 16'd10);
      expect_seq("t5r", 16'd11);

      // SKIP over two-word LDS at pc 5
      mem[5] = 16'h9000; mem[6] = 16'h0ABC;
      do_reset();
      instr_ready = 1'b1;
      for (int p = 0; p < 4; p++) expect_seq("t6", 16'(p));
      expect_instr("t6_skip", 16'd4, mem[4], 16'h0000, 1'b0, 3'd3);
      check_eq("t6_hold", 32'(instr_valid), 32'd0);
      expect_seq("t6", 16'd7);
      expect_seq("t6", 16'd8);

      // PC_W=8 wrap: two-word at 0xFF, ABS, REL +0x7FF from 0xFE
      fill_mem();
      mem[8'hFF] = 16'h940E; mem[0] = 16'h0055;
      do_reset();
      instr_ready_b = 1'b1;
      jmp_b = 8'hFE; pc_src_b = 3'd2;
      @(negedge CLK);
      pc_src_b = 3'd0;
      expect_b("t7_fe", 8'hFE, 16'h00FE, 16'h0000, 1'b0, 3'd0);
      expect_b("t7_ff", 8'hFF, 16'h940E, 16'h0055, 1'b1, 3'd0);
      jmp_b = 8'hFE;
      expect_b("t7_01", 8'h01, 16'h0001, 16'h0000, 1'b0, 3'd2);
      rel_off_b = 12'h7FF;
      expect_b("t7_rel", 8'hFE, 16'h00FE, 16'h0000, 1'b0, 3'd1);
      expect_b("t7_wrap", 8'hFE, 16'h00FE, 16'h0000, 1'b0, 3'd0);
      expect_b("t7_ff2", 8'hFF, 16'h940E, 16'h0055, 1'b1, 3'd0);

      // Asynchronous reset mid-operation, then restart from 0
      fill_mem();
      lat = 1;
      do_reset();
      instr_ready = 1'b1; instr_ready_b = 1'b1;
      repeat (6) @(negedge CLK);
      #3 RST = 1'b0;
      #1;
      check_eq("t8_req",     32'(prog_req),      32'd0);
      check_eq("t8_valid",   32'(instr_valid),   32'd0);
      check_eq("t8_lvl",     32'(queue_level),   32'd0);
      check_eq("t8_pc",      32'(instr_pc),      32'd0);
      check_eq("t8_valid_b", 32'(instr_valid_b), 32'd0);
      do_reset();
      instr_ready = 1'b1;
      expect_seq("t8", 16'd0);
      expect_seq("t8", 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/avr_fetch_q.md
Name: avr_fetch_q

Overview:
Parametrised prefetching instruction-fetch unit for the AVR core, the successor to avr_fetch. It streams 16-bit words from program memory through an in-order request/response port into a DEPTH-entry prefetch queue. It assembles one- and two-word AVR instructions and hands them to avr_cpu over a valid/ready handshake. It supports sequential fetch, relative branch, absolute jump and skip-next, and squashes in-flight memory responses on redirect.

Parameters:
PC_W, 16, program word-address width; all PC arithmetic is modulo 2^PC_W
DEPTH, 4, prefetch queue depth in 16-bit words; power of two, minimum 2
REL_W, 12, width of signed relative branch offset

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
pc_src  in  3  flow control: 0 SEQ, 1 REL, 2 ABS, 3 SKIP, 4-7 treated as SEQ
jmp  in  PC_W  absolute target for ABS
rel_off  in  REL_W  signed word offset for REL
prog_req  out  1  read request, always accepted by memory
prog_addr  out  PC_W  word address of the request
prog_valid  in  1  read data valid; responses in order, latency >= 1, at most one per cycle
prog_data  in  16  read data
cur_instr  out  16  first word of head instruction
instr_k  out  16  second word when instr_is32, else 0
instr_is32  out  1  head instruction is two-word (JMP/CALL: 1001_010x_xxxx_11xx; LDS/STS: 1001_00xx_xxxx_0000)
instr_pc  out  PC_W  address of the first word of the head instruction
instr_valid  out  1  head instruction complete and deliverable
instr_ready  in  1  CPU accepts the head instruction
queue_level  out  $clog2(DEPTH)+1  words currently held in the queue

Behaviour:
- Reset (RST low, async): fetch_pc=0, queue empty, inflight=0, drop_cnt=0, skip_pend=0, next_pc=0. Outputs: prog_req=0, instr_valid=0, cur_instr=0, instr_k=0, instr_is32=0, instr_pc=0, queue_level=0.
- Issue: prog_req=1 when queue_level+inflight < DEPTH and RST high. prog_addr=fetch_pc. On each edge with prog_req=1, fetch_pc increments by 1 (wraps) and inflight increments.
- Response: prog_valid decrements inflight. If drop_cnt>0, the word is discarded and drop_cnt decrements; otherwise it is pushed with its address. The queue can never overflow, by credit; an overflow is an assertion failure.
- Delivery: instr_valid=1 when the head word is present and either it is one-word, or it is two-word and the second word is also present. Outputs are combinational from the queue head. A two-word instruction whose first word is at 2^PC_W-1 takes its second word from address 0.
- Accept: instr_valid & instr_ready pops 1 or 2 words. next_pc <= instr_pc + size.
- SKIP (pc_src=3, sampled each edge): sets skip_pend. While skip_pend=1, instr_valid is held 0. The next complete head instruction (1 or 2 words) is popped internally and skip_pend clears. Skip latency is 1 cycle if the instruction is already queued.
- REL/ABS: on the edge, the queue is flushed, drop_cnt <= inflight minus any response arriving that edge, and skip_pend clears.
  - fetch_pc <= jmp for ABS.
  - fetch_pc <= next_pc' + sign_extend(rel_off) for REL, where next_pc' is the value after any accept on the same edge.
  - An instruction accepted on the redirect edge counts as consumed. No word fetched before the redirect is ever delivered.
  - First new prog_req is on the cycle after the redirect.
- Redirect and SKIP cannot coincide; pc_src encodes one action per cycle.
- Throughput: with 1-cycle memory latency and instr_ready held high, one 16-bit instruction is delivered per cycle after a 2-cycle startup.
- Reset asserted mid-operation discards all state immediately. Responses arriving after reset release without a matching post-reset request are a bench error.

Test Plan:
- Reset then free-run, memory words 0..7 all NOP, 1-cycle latency, instr_ready=1 -> instr_valid rises in cycle 2; instr_pc 0,1,2,... one per cycle; queue_level never exceeds 4.
- Word 2=0x940C (JMP), word 3=0x0010 -> single delivery with instr_is32=1, cur_instr=0x940C, instr_k=0x0010, instr_pc=2; next instr_pc=4.
- Memory latency 3 and instr_ready=0 -> prog_req stops with queue_level+inflight=4. After ready=1, words delivered in order with no loss or duplication.
- ABS jmp=0x0100 issued with 3 responses in flight -> those 3 responses dropped; next delivered instr_pc=0x0100; prog_addr sequence resumes at 0x0100.
- REL rel_off=-3 after accepting instruction at pc 10 -> next instr_pc=8. With rel_off=0x7FF at PC_W=8 from pc 0xFE -> wraps to 0xFE.
- SKIP while head is the two-word LDS at pc 5 -> pc 5 never presented; next instr_pc=7; skip_pend cleared.
